cdb_arbiter: RTL and testbench
==============================

# cdb_arbiter

Parametrised write-back stage between the functional units and the common data buses (CDBs). Each of NUM_FU units pushes results into its own FIFO through a valid/ready handshake. Each cycle, up to NUM_CDB results are granted round-robin onto registered CDB lanes. It replaces the fixed one-unit-per-bus write-back, so more units than buses can share the broadcast path without dropping results, and a pipeline flush discards all in-flight results.

## Interface
- NUM_FU, 4: number of functional-unit inputs (≥2).
- NUM_CDB, 2: number of CDB output lanes (1 ≤ NUM_CDB ≤ NUM_FU).
- BUF_DEPTH, 2: entries per FU FIFO (power of 2, ≥2).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- flush  in  1  synchronous squash of all buffered and outgoing results.
- fu_out[NUM_FU]  in  funct_unit_out_t  unit results; .out_valid is the push request.
- fu_ready[NUM_FU]  out  1  FIFO i can accept this cycle.
- cdb[NUM_CDB]  out  CDB_t  registered broadcast; .we marks a valid lane.
- busy  out  1  any FIFO non-empty or any cdb[k].we set.

## Operation
- **Push.** Unit i is accepted when fu_out[i].out_valid && fu_ready[i]. The result is written at the FIFO tail.
- **Ready rule.** fu_ready[i] = (count[i] != BUF_DEPTH) && !flush.
  - It depends on registered count only. A full FIFO is not ready even if it pops in the same cycle.
  - count width is $clog2(BUF_DEPTH+1); pointer width is $clog2(BUF_DEPTH), wrapping mod BUF_DEPTH.
- **Arbitration.** Scan FIFOs in order rr_ptr, rr_ptr+1, … mod NUM_FU. The first NUM_CDB non-empty FIFOs are granted and popped.
  - The j-th grant in scan order drives lane j.
  - Lanes with no grant load all-zero (we=0).
- **rr_ptr update.** rr_ptr becomes (last granted index + 1) mod NUM_FU. It is unchanged if nothing is granted.
- **Simultaneous push and pop.** Allowed on the same FIFO. Count is unchanged and the data order is preserved.
- **Lane formation** (from FIFO head h), registered into cdb[j]:
  - Direct copies: depen, br_en, rob_idx, pc, inst; pd = h.pd_idx; rd = h.rd_idx; we = 1.
  - pc_next = h.pc_next if h.br_jump_sel != 0, else h.pc + 4.
  - funct_out = h.pc + 4 if br_jump_sel is jump or jump_link, else h.funct_out.
  - All pc + 4 arithmetic is 32-bit and wraps mod 2^32.
  - rvfi_val is zeroed, then filled: inst, src_1_v, src_2_v, rd_s = rd_idx, pc, pc_next. src_*_s and all mem_* fields are 0.
- **Flush.** On the flush edge:
  - all counts and pointers clear;
  - all cdb lanes clear;
  - rr_ptr resets to 0;
  - pushes offered during the flush cycle are dropped.
  
  Flush and rst have identical effect; rst has priority if both are asserted.

## Timing
- **Reset values.** cdb[*] all-zero; fu_ready[*] = 1 from the first cycle after rst deasserts (0 while rst or flush is high); busy = 0; rr_ptr = 0; all counts = 0.
- **Latency.** A result accepted in cycle c occupies its FIFO in c+1, is granted in c+1 if it wins, and appears on cdb in c+2. Minimum latency is 2 cycles.
- **Lane lifetime.** A cdb lane is valid for exactly one cycle per result. There is no back-pressure from the CDB side.
- **Throughput.** Each FU sustains one result per cycle only while it wins a grant every cycle. Otherwise it stalls via fu_ready after BUF_DEPTH results queue up.
- **Ordering.** Per-FU ordering is strict FIFO. There is no ordering guarantee across FUs.
- **Mid-operation reset or flush.** An assertion while FIFOs are full or lanes are valid empties everything the next cycle. No stale we=1 may appear after the flush edge.

## Test plan
- **Reset.** Hold rst 3 cycles with random fu_out → all cdb.we=0, busy=0, fu_ready=0 during reset. fu_ready=1 in the first cycle after reset.
- **Single push.** FU0 pushes pc=0x1000, br_jump_sel=0, funct_out=0x55, rob_idx=3 in cycle 5 → cdb[0] in cycle 7: we=1, funct_out=0x55, pc_next=0x1004, rob_idx=3. cdb[1].we=0.
- **Jump-link.** FU1 pushes pc=0xFFFFFFFC, br_jump_sel=jump_link, pc_next=0x2000 → cdb funct_out=0x00000000 (wrap), pc_next=0x2000.
- **Fairness under contention.** Defaults; all 4 FUs push every cycle for 20 cycles → each FU receives 10 grants. Lanes rotate {0,1},{2,3},{0,1},… from rr_ptr=0. fu_ready drops only when a FIFO reaches 2 entries. No result is lost or reordered per FU (scoreboard on rob_idx).
- **Backpressure.** NUM_CDB=1; FU2 pushes 3 results back-to-back while FU0 and FU1 hold their FIFOs non-empty → fu_ready[2]=0 once count=2. The third result is held at the FU and accepted only after a pop.
- **Flush.** Flush with 2 entries queued in every FIFO and both lanes valid → the next cycle shows cdb.we=0 on all lanes, busy=0, rr_ptr=0. A push offered in the flush cycle never appears on cdb.

Source files
------------

// File: rtl/cdb_arbiter_if.sv
// ============================================================================
// Module      : cdb_pkg / cdb_arbiter_if
// Description : Result/CDB record types and the FU-to-CDB write-back bus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cdb_pkg;

  typedef enum logic [1:0] {
    BR_NONE      = 2'd0,
    BR_BRANCH    = 2'd1,
    BR_JUMP      = 2'd2,
    BR_JUMP_LINK = 2'd3
  } br_jump_sel_t;

  typedef struct packed {
    logic         out_valid;
    logic [3:0]   depen;
    logic         br_en;
    logic [5:0]   rob_idx;
    logic [31:0]  pc;
    logic [31:0]  inst;
    logic [5:0]   pd_idx;
    logic [4:0]   rd_idx;
    br_jump_sel_t br_jump_sel;
    logic [31:0]  pc_next;
    logic [31:0]  funct_out;
    logic [31:0]  src_1_v;
    logic [31:0]  src_2_v;
  } funct_unit_out_t;

  typedef struct packed {
    logic [31:0] inst;
    logic [4:0]  src_1_s;
    logic [4:0]  src_2_s;
    logic [31:0] src_1_v;
    logic [31:0] src_2_v;
    logic [4:0]  rd_s;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic [31:0] mem_addr;
    logic [3:0]  mem_rmask;
    logic [3:0]  mem_wmask;
    logic [31:0] mem_rdata;
    logic [31:0] mem_wdata;
  } rvfi_t;

  typedef struct packed {
    logic        we;
    logic [3:0]  depen;
    logic        br_en;
    logic [5:0]  rob_idx;
    logic [31:0] pc;
    logic [31:0] inst;
    logic [5:0]  pd;
    logic [4:0]  rd;
    logic [31:0] pc_next;
    logic [31:0] funct_out;
    rvfi_t       rvfi_val;
  } CDB_t;

endpackage

interface cdb_arbiter_if #(
  parameter int NUM_FU  = 4,
  parameter int NUM_CDB = 2
) ();
  import cdb_pkg::*;

  funct_unit_out_t fu_out   [NUM_FU];
  logic            fu_ready [NUM_FU];
  CDB_t            cdb      [NUM_CDB];
  logic            busy;

  modport master (output fu_out, input fu_ready, input cdb, input busy);
  modport slave  (input fu_out, output fu_ready, output cdb, output busy);
endinterface

`default_nettype wire

// File: rtl/cdb_arbiter.sv
// ============================================================================
// Module      : cdb_arbiter
// Description : Per-FU result FIFOs with round-robin grant onto NUM_CDB lanes.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module cdb_arbiter
  import cdb_pkg::*;
#(
  parameter int NUM_FU    = 4,
  parameter int NUM_CDB   = 2,
  parameter int BUF_DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         flush,
  cdb_arbiter_if.slave bus
);

  localparam int FU_W  = (NUM_FU > 1) ? $clog2(NUM_FU) : 1;
  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = $clog2(BUF_DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL = CNT_W'(BUF_DEPTH);

  logic [NUM_FU-1:0]  nonempty;
  logic [NUM_FU-1:0]  ready;
  logic [NUM_FU-1:0]  pop;
  funct_unit_out_t    head_ent [NUM_FU];
  logic [NUM_CDB-1:0] lane_vld;
  logic [FU_W-1:0]    lane_src [NUM_CDB];
  logic [NUM_CDB-1:0] lane_we;
  logic [FU_W-1:0]    rr_ptr;
  logic [FU_W-1:0]    rr_next;
  logic               any_grant;

  function automatic CDB_t form_lane(funct_unit_out_t h);
    CDB_t        l;
    logic [31:0] link;
    link = h.pc + 32'd4;
    l = '0;
    l.we        = 1'b1;
    l.depen     = h.depen;
    l.br_en     = h.br_en;
    l.rob_idx   = h.rob_idx;
    l.pc        = h.pc;
    l.inst      = h.inst;
    l.pd        = h.pd_idx;
    l.rd        = h.rd_idx;
    l.pc_next   = (h.br_jump_sel != BR_NONE) ? h.pc_next : link;
    l.funct_out = (h.br_jump_sel == BR_JUMP || h.br_jump_sel == BR_JUMP_LINK) ? link : h.funct_out;
    l.rvfi_val.inst    = h.inst;
    l.rvfi_val.src_1_v = h.src_1_v;
    l.rvfi_val.src_2_v = h.src_2_v;
    l.rvfi_val.rd_s    = h.rd_idx;
    l.rvfi_val.pc      = h.pc;
    l.rvfi_val.pc_next = l.pc_next;
    return l;
  endfunction

  for (genvar i = 0; i < NUM_FU; i++) begin : g_fifo
    funct_unit_out_t  mem [BUF_DEPTH];
    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [CNT_W-1:0] count;
    logic             do_push;

    // Ready looks only at the registered count, so a full FIFO stays
    // not-ready even in a cycle where it is also being popped.
    assign ready[i]        = (count != FULL) && !flush && !rst;
    assign do_push         = bus.fu_out[i].out_valid && ready[i];
    assign nonempty[i]     = (count != '0);
    assign head_ent[i]     = mem[head];
    assign bus.fu_ready[i] = ready[i];

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        head  <= '0;
        tail  <= '0;
        count <= '0;
      end else begin
        if (do_push) begin
          mem[tail] <= bus.fu_out[i];
          tail      <= tail + 1'b1;
        end
        if (pop[i]) begin
          head <= head + 1'b1;
        end
        if (do_push && !pop[i]) begin
          count <= count + 1'b1;
        end else if (!do_push && pop[i]) begin
          count <= count - 1'b1;
        end
      end
    end
  end

  // Scan from rr_ptr; the j-th non-empty FIFO found drives lane j.
  always_comb begin
    int   idx_k;
    int   rank;
    logic cand;
    logic gnt;
    idx_k     = 0;
    rank      = 0;
    cand      = 1'b0;
    gnt       = 1'b0;
    pop       = '0;
    lane_vld  = '0;
    any_grant = 1'b0;
    rr_next   = rr_ptr;
    for (int j = 0; j < NUM_CDB; j++) begin
      lane_src[j] = '0;
    end
    for (int k = 0; k < NUM_FU; k++) begin
      idx_k = (int'(rr_ptr) + k) % NUM_FU;
      cand  = 1'b0;
      for (int i = 0; i < NUM_FU; i++) begin
        if (idx_k == i) cand = nonempty[i];
      end
      gnt = cand && (rank < NUM_CDB);
      for (int j = 0; j < NUM_CDB; j++) begin
        if (gnt && rank == j) begin
          lane_vld[j] = 1'b1;
          lane_src[j] = FU_W'(idx_k);
        end
      end
      for (int i = 0; i < NUM_FU; i++) begin
        if (gnt && idx_k == i) pop[i] = 1'b1;
      end
      if (gnt) begin
        rank      = rank + 1;
        any_grant = 1'b1;
        rr_next   = FU_W'((idx_k + 1) % NUM_FU);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      rr_ptr <= '0;
    end else if (any_grant) begin
      rr_ptr <= rr_next;
    end
  end

  for (genvar j = 0; j < NUM_CDB; j++) begin : g_lane
    CDB_t cdb_q;

    always_ff @(posedge clk) begin
      if (rst || flush) begin
        cdb_q <= '0;
      end else if (lane_vld[j]) begin
        cdb_q <= form_lane(head_ent[lane_src[j]]);
      end else begin
        cdb_q <= '0;
      end
    end

    assign bus.cdb[j] = cdb_q;
    assign lane_we[j] = cdb_q.we;
  end

  assign bus.busy = (|nonempty) || (|lane_we);

endmodule

`default_nettype wire

// File: tb/tb_cdb_arbiter.sv
// ============================================================================
// Module      : tb_cdb_arbiter
// Description : Randomised and directed bench for two cdb_arbiter builds.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_cdb_arbiter;
  import cdb_pkg::*;

  localparam int NUM_FU    = 4;
  localparam int BUF_DEPTH = 2;

  logic clk = 1'b0;
  logic rst;
  logic flush;
  always #5 clk = ~clk;

  cdb_arbiter_if #(.NUM_FU(NUM_FU), .NUM_CDB(2)) bus0 ();
  cdb_arbiter_if #(.NUM_FU(NUM_FU), .NUM_CDB(1)) bus1 ();

  cdb_arbiter #(.NUM_FU(NUM_FU), .NUM_CDB(2), .BUF_DEPTH(BUF_DEPTH)) u_dut0 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus0)
  );
  cdb_arbiter #(.NUM_FU(NUM_FU), .NUM_CDB(1), .BUF_DEPTH(BUF_DEPTH)) u_dut1 (
    .clk(clk), .rst(rst), .flush(flush), .bus(bus1)
  );

  funct_unit_out_t fin [2][NUM_FU];
  for (genvar i = 0; i < NUM_FU; i++) begin : g_drv
    assign bus0.fu_out[i] = fin[0][i];
    assign bus1.fu_out[i] = fin[1][i];
  end

  // Reference: one queue per FU, expected lanes and round-robin start per build.
  funct_unit_out_t mq   [2][NUM_FU][$];
  CDB_t            mcdb [2][2];
  int              mrr  [2];
  int              ncdb [2];
  bit              want [2][NUM_FU];
  int              gcount [NUM_FU];
  bit              count_en;
  int              seq;
  int              checks;
  int              failures;

  task automatic chk_bit(string tag, logic obs, logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk_val(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_lane(string tag, CDB_t obs, CDB_t exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic funct_unit_out_t rand_item(int d, int i);
    funct_unit_out_t t;
    t.out_valid   = 1'b1;
    t.depen       = 4'($urandom);
    t.br_en       = 1'($urandom);
    t.rob_idx     = 6'(seq);
    t.pc          = $urandom;
    t.inst        = {2'(i), 1'(d), 29'(seq)};
    t.pd_idx      = 6'($urandom);
    t.rd_idx      = 5'($urandom);
    t.br_jump_sel = br_jump_sel_t'($urandom_range(0, 3));
    t.pc_next     = $urandom;
    t.funct_out   = $urandom;
    t.src_1_v     = $urandom;
    t.src_2_v     = $urandom;
    seq++;
    return t;
  endfunction

  function automatic CDB_t exp_lane(funct_unit_out_t h);
    CDB_t        e;
    logic [31:0] seq_pc;
    seq_pc = h.pc + 32'd4;
    e = '0;
    e.we      = 1'b1;
    e.depen   = h.depen;
    e.br_en   = h.br_en;
    e.rob_idx = h.rob_idx;
    e.pc      = h.pc;
    e.inst    = h.inst;
    e.pd      = h.pd_idx;
    e.rd      = h.rd_idx;
    e.pc_next = (h.br_jump_sel == BR_NONE) ? seq_pc : h.pc_next;
    case (h.br_jump_sel)
      BR_JUMP, BR_JUMP_LINK: e.funct_out = seq_pc;
      default:               e.funct_out = h.funct_out;
    endcase
    e.rvfi_val.inst    = h.inst;
    e.rvfi_val.src_1_v = h.src_1_v;
    e.rvfi_val.src_2_v = h.src_2_v;
    e.rvfi_val.rd_s    = h.rd_idx;
    e.rvfi_val.pc      = h.pc;
    e.rvfi_val.pc_next = e.pc_next;
    return e;
  endfunction

  task automatic cycle();
    bit acc [2][NUM_FU];
    bit exp_rdy;
    bit exp_busy;
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NUM_FU; i++)
        if (want[d][i] && !fin[d][i].out_valid) fin[d][i] = rand_item(d, i);
    #1;
    for (int d = 0; d < 2; d++) begin
      for (int i = 0; i < NUM_FU; i++) begin
        exp_rdy = !rst && !flush && (mq[d][i].size() < BUF_DEPTH);
        chk_bit($sformatf("fu_ready d%0d fu%0d", d, i),
                (d == 0) ? bus0.fu_ready[i] : bus1.fu_ready[i], exp_rdy);
        acc[d][i] = exp_rdy && fin[d][i].out_valid;
      end
    end
    for (int d = 0; d < 2; d++) begin
      if (rst || flush) begin
        for (int i = 0; i < NUM_FU; i++) mq[d][i].delete();
        mcdb[d][0] = '0;
        mcdb[d][1] = '0;
        mrr[d] = 0;
      end else begin
        int n;
        int last;
        n = 0;
        last = -1;
        mcdb[d][0] = '0;
        mcdb[d][1] = '0;
        for (int k = 0; k < NUM_FU; k++) begin
          int f;
          f = (mrr[d] + k) % NUM_FU;
          if (n < ncdb[d] && mq[d][f].size() > 0) begin
            mcdb[d][n] = exp_lane(mq[d][f].pop_front());
            n++;
            last = f;
          end
        end
        if (last >= 0) mrr[d] = (last + 1) % NUM_FU;
        for (int i = 0; i < NUM_FU; i++)
          if (acc[d][i]) mq[d][i].push_back(fin[d][i]);
      end
    end
    @(posedge clk);
    #1;
    chk_lane("cdb d0 lane0", bus0.cdb[0], mcdb[0][0]);
    chk_lane("cdb d0 lane1", bus0.cdb[1], mcdb[0][1]);
    chk_lane("cdb d1 lane0", bus1.cdb[0], mcdb[1][0]);
    for (int d = 0; d < 2; d++) begin
      exp_busy = mcdb[d][0].we || mcdb[d][1].we;
      for (int i = 0; i < NUM_FU; i++) if (mq[d][i].size() != 0) exp_busy = 1'b1;
      chk_bit($sformatf("busy d%0d", d), (d == 0) ? bus0.busy : bus1.busy, exp_busy);
    end
    if (count_en) begin
      for (int j = 0; j < 2; j++)
        if (bus0.cdb[j].we === 1'b1) gcount[int'(bus0.cdb[j].inst[31:30])]++;
    end
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NUM_FU; i++)
        if (acc[d][i]) fin[d][i].out_valid = 1'b0;
  endtask

  task automatic set_want(int d, bit v);
    for (int i = 0; i < NUM_FU; i++) want[d][i] = v;
  endtask

  task automatic clear_inputs();
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < NUM_FU; i++) begin
        fin[d][i]  = '0;
        want[d][i] = 1'b0;
      end
  endtask

  initial begin
    funct_unit_out_t t;
    checks = 0; failures = 0; seq = 0; count_en = 1'b0;
    ncdb[0] = 2; ncdb[1] = 1; mrr[0] = 0; mrr[1] = 0;
    mcdb[0][0] = '0; mcdb[0][1] = '0; mcdb[1][0] = '0; mcdb[1][1] = '0;
    for (int i = 0; i < NUM_FU; i++) gcount[i] = 0;
    clear_inputs();
    flush = 1'b0;
    rst   = 1'b1;

    // Reset held 3 cycles with random offers on every FU.
    for (int c = 0; c < 3; c++) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NUM_FU; i++) fin[d][i] = rand_item(d, i);
      cycle();
    end
    clear_inputs();
    rst = 1'b0;
    cycle();
    cycle();

    // Single push: result appears two edges later on lane 0.
    t = '0;
    t.out_valid = 1'b1; t.pc = 32'h0000_1000; t.funct_out = 32'h55;
    t.rob_idx = 6'd3; t.br_jump_sel = BR_NONE; t.inst = 32'h0000_00aa;
    fin[0][0] = t;
    cycle();
    cycle();
    chk_bit("single we", bus0.cdb[0].we, 1'b1);
    chk_val("single funct_out", bus0.cdb[0].funct_out, 32'h55);
    chk_val("single pc_next", bus0.cdb[0].pc_next, 32'h1004);
    chk_val("single rob_idx", 32'(bus0.cdb[0].rob_idx), 32'd3);
    chk_bit("single lane1 we", bus0.cdb[1].we, 1'b0);
    cycle();

    // Jump-link at the top of the address space wraps the link value.
    t = '0;
    t.out_valid = 1'b1; t.pc = 32'hFFFF_FFFC; t.br_jump_sel = BR_JUMP_LINK;
    t.pc_next = 32'h0000_2000; t.funct_out = 32'hDEAD_BEEF; t.inst = 32'h4000_0001;
    fin[0][1] = t;
    cycle();
    cycle();
    chk_val("jal funct_out", bus0.cdb[0].funct_out, 32'h0000_0000);
    chk_val("jal pc_next", bus0.cdb[0].pc_next, 32'h0000_2000);
    cycle();

    // Fairness: all FUs push for 20 cycles starting from rr_ptr = 0.
    rst = 1'b1; cycle(); rst = 1'b0;
    for (int c = 0; c < 22; c++) begin
      set_want(0, c < 20);
      count_en = (c >= 1 && c <= 20);
      cycle();
    end
    count_en = 1'b0;
    for (int i = 0; i < NUM_FU; i++)
      chk_val($sformatf("fair grants fu%0d", i), 32'(gcount[i]), 32'd10);
    for (int c = 0; c < 12; c++) cycle();

    // Backpressure on the single-lane build: FU2 stalls at two entries.
    rst = 1'b1; cycle(); rst = 1'b0;
    want[1][0] = 1'b1; want[1][1] = 1'b1; want[1][2] = 1'b1;
    for (int c = 0; c < 10; c++) begin
      if (c == 2 || c == 3) chk_bit($sformatf("bp ready2 c%0d", c), bus1.fu_ready[2], 1'b0);
      if (c == 4) chk_bit("bp ready2 c4", bus1.fu_ready[2], 1'b1);
      cycle();
    end
    set_want(1, 1'b0);
    for (int c = 0; c < 16; c++) cycle();

    // Flush with queues loaded and both lanes valid.
    set_want(0, 1'b1);
    for (int c = 0; c < 6; c++) cycle();
    chk_bit("preflush lane0 we", bus0.cdb[0].we, 1'b1);
    chk_bit("preflush lane1 we", bus0.cdb[1].we, 1'b1);
    for (int i = 0; i < NUM_FU; i++)
      if (!fin[0][i].out_valid) fin[0][i] = rand_item(0, i);
    flush = 1'b1;
    cycle();
    flush = 1'b0;
    clear_inputs();
    chk_bit("flush lane0 we", bus0.cdb[0].we, 1'b0);
    chk_bit("flush lane1 we", bus0.cdb[1].we, 1'b0);
    chk_bit("flush busy", bus0.busy, 1'b0);
    chk_val("flush rr_ptr", 32'(u_dut0.rr_ptr), 32'd0);
    for (int c = 0; c < 4; c++) cycle();

    // Random traffic with occasional flush and reset on both builds.
    for (int c = 0; c < 400; c++) begin
      for (int d = 0; d < 2; d++)
        for (int i = 0; i < NUM_FU; i++) want[d][i] = ($urandom_range(0, 3) != 0);
      flush = ($urandom_range(0, 19) == 0);
      rst   = ($urandom_range(0, 63) == 0);
      cycle();
    end
    flush = 1'b0;
    rst   = 1'b0;
    set_want(0, 1'b0);
    set_want(1, 1'b0);
    for (int c = 0; c < 20; c++) cycle();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
